ibus_mem_resp: RTL and testbench

//  Responder end of the instruction-bus protocol driven by the fetch unit: accepts ibus_req_t, returns ibus_resp_t.

---
 rtl/ibus_mem_resp.sv | 187 ++++++++++++++++++
 tb/tb_ibus_mem_resp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ibus_mem_resp.sv
// ibus_mem_resp: responder end of the instruction bus. It is a word-addressed
// instruction memory with a fixed, programmable access latency and a loader
// write port for preloading code. It serves as on-chip boot/instruction RAM
// and as the ibus target in unit and system simulations.
//
// Optional feature macro: IBUS_RESP_RANGE_CHK_EN. When defined, fetches outside
// [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) return a nop and pulse acc_fault. When
// undefined, out-of-window addresses wrap modulo DEPTH_WORDS and acc_fault is 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (memory contents are kept)
//   ireq       {valid, addr[63:0]} from the fetch unit
//   iresp      {addr_ok, data_ok, data[31:0]} to the fetch unit, all registered
//   ld_we      loader write enable (honoured at any edge, in any state)
//   ld_addr    loader byte address, same map as ireq.addr
//   ld_data    loader write data
//   acc_fault  out-of-window fetch flag, high only in the data_ok cycle
//
// Handshake: ireq.valid is sampled only in IDLE. The accepting edge latches
// the address and raises addr_ok for one cycle. data_ok then pulses for exactly
// one cycle, LATENCY cycles after the accept edge. Only one request can be
// outstanding. The requester must drop valid, or present its next request, at
// the edge that ends the data_ok cycle. iresp.data holds the last returned word
// until the next data_ok.

package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_mem_resp
  import ibus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  logic        ld_we,
  input  logic [63:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        acc_fault
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [31:0] NOP    = 32'h0000_0013;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ibus_mem_resp: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [31:0] mem [DEPTH_WORDS];

  // Word index is the byte offset from BASE_ADDR, with bits above the window
  // dropped. Those dropped bits are what make out-of-window addresses wrap.
  logic [63:0]   req_off;
  logic [63:0]   ld_off;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] ld_idx;
  logic          unused_off;

  assign req_off    = ireq.addr - BASE_ADDR;
  assign ld_off     = ld_addr - BASE_ADDR;
  assign req_idx    = req_off[AW+1:2];
  assign ld_idx     = ld_off[AW+1:2];
  assign unused_off = ^{req_off[63:AW+2], req_off[1:0], ld_off[63:AW+2], ld_off[1:0]};

  // The loader writes at any edge. A fetch read on the same edge to the same
  // index sees the old word, because the write is non-blocking.
  always_ff @(posedge clk) begin
    if (ld_we) mem[ld_idx] <= ld_data;
  end

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          addr_ok_q;
  logic          data_ok_q;
  logic [31:0]   data_q;
  logic          fault_q;

`ifdef IBUS_RESP_RANGE_CHK_EN
  logic req_in_win;
  logic win_q;
  logic fault_out;

  assign req_in_win = (ireq.addr >= BASE_ADDR) && (req_off < 64'(4 * DEPTH_WORDS));
  assign fault_q    = fault_out;
  assign acc_fault  = fault_out;
`else
  assign fault_q   = 1'b0;
  assign acc_fault = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      data_q    <= 32'h0;
`ifdef IBUS_RESP_RANGE_CHK_EN
      win_q     <= 1'b1;
      fault_out <= 1'b0;
`endif
    end else begin
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
`ifdef IBUS_RESP_RANGE_CHK_EN
      fault_out <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (ireq.valid) begin
            idx_q     <= req_idx;
            cnt       <= LAT_M1;
            addr_ok_q <= 1'b1;
`ifdef IBUS_RESP_RANGE_CHK_EN
            win_q     <= req_in_win;
`endif
            if (LATENCY == 1) begin
              // Single-cycle latency: the accept edge is also the read edge.
              data_ok_q <= 1'b1;
`ifdef IBUS_RESP_RANGE_CHK_EN
              data_q    <= req_in_win ? mem[req_idx] : NOP;
              fault_out <= !req_in_win;
`else
              data_q    <= mem[req_idx];
`endif
              state     <= RESP;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // ireq is ignored here. The latched index is used even if the
          // requester drops valid or changes the address.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            data_ok_q <= 1'b1;
`ifdef IBUS_RESP_RANGE_CHK_EN
            data_q    <= win_q ? mem[idx_q] : NOP;
            fault_out <= !win_q;
`else
            data_q    <= mem[idx_q];
`endif
            state     <= RESP;
          end
        end
        RESP: begin
          // data_ok cycle. valid is ignored, which guarantees at least one
          // idle cycle before the next accept.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign iresp = '{addr_ok: addr_ok_q, data_ok: data_ok_q, data: data_q};

  logic unused_fault;
  assign unused_fault = fault_q;

endmodule

// File: tb/tb_ibus_mem_resp.sv
// tb_ibus_mem_resp: directed bench for ibus_mem_resp. It uses three instances
// at LATENCY 1, 2 and 4 that share clock, reset and the loader bus, so a
// loader write lands in all three memories. Each instance has its own request
// and response signals.
//
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// that same point, so they show what the preceding edge registered.

module tb_ibus_mem_resp;
  import ibus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_we = 1'b0;
  logic [63:0] ld_addr = 64'h0;
  logic [31:0] ld_data = 32'h0;

  ibus_req_t   r1, r2, r4;
  ibus_resp_t  s1, s2, s4;
  logic        f1, f2, f4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibus_mem_resp #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .ireq(r1), .iresp(s1),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .acc_fault(f1)
  );
  ibus_mem_resp #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .ireq(r2), .iresp(s2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .acc_fault(f2)
  );
  ibus_mem_resp #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .ireq(r4), .iresp(s4),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .acc_fault(f4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we   = 1'b0;
  endtask

  logic seen;

  initial begin
    r1 = '0;
    r2 = '0;
    r4 = '0;

    // Reset state
    #12;
    check("rst_aok_l1", 64'(s1.addr_ok), 64'd0);
    check("rst_dok_l2", 64'(s2.data_ok), 64'd0);
    check("rst_data_l4", 64'(s4.data), 64'h0);
    check("rst_fault_l2", 64'(f2), 64'd0);
    rst = 1'b0;

    // Preload words 0..3 into all three memories.
    load(64'h8000_0000, 32'h0010_0093);
    load(64'h8000_0004, 32'h0020_0113);
    load(64'h8000_0008, 32'h0030_0193);
    load(64'h8000_000C, 32'h0040_0213);

    // Test 1: LATENCY=2, valid held until data_ok.
    r2 = '{valid: 1'b1, addr: 64'h8000_0000};
    step();
    check("t1_aok", 64'(s2.addr_ok), 64'd1);
    check("t1_dok_early", 64'(s2.data_ok), 64'd0);
    step();
    check("t1_aok_pulse", 64'(s2.addr_ok), 64'd0);
    check("t1_dok", 64'(s2.data_ok), 64'd1);
    check("t1_data", 64'(s2.data), 64'h0010_0093);
    check("t1_fault", 64'(f2), 64'd0);
    r2.valid = 1'b0;
    step();
    check("t1_dok_pulse", 64'(s2.data_ok), 64'd0);
    check("t1_data_hold", 64'(s2.data), 64'h0010_0093);

    // Test 2: LATENCY=1, back-to-back fetches with valid held throughout.
    r1 = '{valid: 1'b1, addr: 64'h8000_0000};
    step();
    check("t2_aok0", 64'(s1.addr_ok), 64'd1);
    check("t2_dok0", 64'(s1.data_ok), 64'd1);
    check("t2_data0", 64'(s1.data), 64'h0010_0093);
    r1.addr = 64'h8000_0004;
    step();
    check("t2_no_accept_aok", 64'(s1.addr_ok), 64'd0);
    check("t2_no_accept_dok", 64'(s1.data_ok), 64'd0);
    step();
    check("t2_aok1", 64'(s1.addr_ok), 64'd1);
    check("t2_dok1", 64'(s1.data_ok), 64'd1);
    check("t2_data1", 64'(s1.data), 64'h0020_0113);
    r1.valid = 1'b0;
    step();
    check("t2_idle_dok", 64'(s1.data_ok), 64'd0);

    // Test 3: LATENCY=4, valid dropped and address changed after accept.
    r4 = '{valid: 1'b1, addr: 64'h8000_0008};
    step();
    check("t3_aok", 64'(s4.addr_ok), 64'd1);
    r4 = '{valid: 1'b0, addr: 64'h8000_000C};
    step();
    check("t3_dok_c2", 64'(s4.data_ok), 64'd0);
    step();
    check("t3_dok_c3", 64'(s4.data_ok), 64'd0);
    step();
    check("t3_dok", 64'(s4.data_ok), 64'd1);
    check("t3_data", 64'(s4.data), 64'h0030_0193);
    step();
    check("t3_dok_pulse", 64'(s4.data_ok), 64'd0);

    // Test 4a: LATENCY=2, loader write on the read edge returns the old word.
    load(64'h8000_0014, 32'h2222_2222);
    r2 = '{valid: 1'b1, addr: 64'h8000_0014};
    step();
    r2.valid = 1'b0;
    ld_we = 1'b1; ld_addr = 64'h8000_0014; ld_data = 32'hDEAD_BEEF;
    step();
    ld_we = 1'b0;
    check("t4_same_edge_dok", 64'(s2.data_ok), 64'd1);
    check("t4_same_edge_old", 64'(s2.data), 64'h2222_2222);
    step();
    r2 = '{valid: 1'b1, addr: 64'h8000_0014};
    step();
    r2.valid = 1'b0;
    step();
    check("t4_refetch_new", 64'(s2.data), 64'hDEAD_BEEF);

    // Test 4b: LATENCY=4, loader write during BUSY returns the new word.
    load(64'h8000_0014, 32'h1111_1111);
    r4 = '{valid: 1'b1, addr: 64'h8000_0014};
    step();
    r4.valid = 1'b0;
    ld_we = 1'b1; ld_addr = 64'h8000_0014; ld_data = 32'hDEAD_BEEF;
    step();
    ld_we = 1'b0;
    step();
    step();
    check("t4_busy_dok", 64'(s4.data_ok), 64'd1);
    check("t4_busy_new", 64'(s4.data), 64'hDEAD_BEEF);
    step();

    // Test 5: asynchronous reset mid-BUSY.
    r4 = '{valid: 1'b1, addr: 64'h8000_0000};
    step();
    check("t5_pre_aok", 64'(s4.addr_ok), 64'd1);
    r4.valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_aok", 64'(s4.addr_ok), 64'd0);
    check("t5_rst_data", 64'(s4.data), 64'h0);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | s4.data_ok;
    end
    check("t5_no_dok", 64'(seen), 64'd0);
    r4 = '{valid: 1'b1, addr: 64'h8000_0008};
    step();
    check("t5_new_aok", 64'(s4.addr_ok), 64'd1);
    r4.valid = 1'b0;
    step();
    step();
    step();
    check("t5_new_dok", 64'(s4.data_ok), 64'd1);
    check("t5_new_data", 64'(s4.data), 64'h0030_0193);
    step();

    // Test 6: fetch just below the window.
    load(64'h8000_3FFC, 32'h1234_5678);
    r2 = '{valid: 1'b1, addr: 64'h7FFF_FFFC};
    step();
    r2.valid = 1'b0;
    step();
    check("t6_dok", 64'(s2.data_ok), 64'd1);
`ifdef IBUS_RESP_RANGE_CHK_EN
    check("t6_data", 64'(s2.data), 64'h0000_0013);
    check("t6_fault", 64'(f2), 64'd1);
`else
    check("t6_data", 64'(s2.data), 64'h1234_5678);
    check("t6_fault", 64'(f2), 64'd0);
`endif
    step();
    check("t6_fault_pulse", 64'(f2), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
